controle_senha_teclado: RTL and testbench

- Keypad PIN-lock controller that sits directly downstream of the matrix keypad decoder.
- Consumes its `tecla_valid`/`tecla_value` pair and collects up to 4 BCD digits into a display buffer for the multiplexed 7-segment driver.
- On confirm, compares the entry against a parameter password and drives unlock/error/lockout indications and the buzzer.
- Runs on the same divided clock as the decoder.

---
 rtl/controle_senha_teclado.sv | 162 ++++++++++++++++
 tb/tb_controle_senha_teclado.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/controle_senha_teclado.sv
// Keypad PIN-lock controller: collects up to four BCD digits, checks them against
// SENHA on '#', and drives unlock / error / lockout indications and the buzzer.
module controle_senha_teclado #(
    parameter logic [15:0] SENHA    = 16'h1234,
    parameter int unsigned T_ABERTO = 2000,
    parameter int unsigned T_BIP    = 200,
    parameter int unsigned T_ERRO   = 1000,
    parameter int unsigned T_BLOQ   = 10000,
    parameter int unsigned MAX_TENT = 3
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              tecla_valid,
    input  logic [3:0]                        tecla_value,
    output logic [15:0]                       digitos,
    output logic [3:0]                        dig_vis,
    output logic                              aberto,
    output logic                              erro,
    output logic                              bloqueado,
    output logic                              buzzer,
    output logic [$clog2(MAX_TENT+1)-1:0]     falhas
);

    localparam int unsigned FW    = $clog2(MAX_TENT + 1);
    localparam int unsigned T_M1  = (T_ABERTO > T_ERRO) ? T_ABERTO : T_ERRO;
    localparam int unsigned T_MAX = (T_M1 > T_BLOQ) ? T_M1 : T_BLOQ;
    localparam int unsigned TW    = (T_MAX > 1) ? $clog2(T_MAX) : 1;

    localparam logic [3:0] TECLA_LIMPA    = 4'hE;
    localparam logic [3:0] TECLA_CONFIRMA = 4'hF;

    typedef enum logic [2:0] {
        ENTRADA,
        VERIFICA,
        ABERTO,
        ERRO,
        BLOQUEIO
    } estado_t;

    estado_t         estado, estado_nxt;
    logic [TW-1:0]   timer, timer_nxt;
    logic [2:0]      cnt, cnt_nxt;
    logic            tv_d;
    logic [15:0]     digitos_nxt;
    logic [3:0]      dig_vis_nxt;
    logic            aberto_nxt, erro_nxt, bloqueado_nxt, buzzer_nxt;
    logic [FW-1:0]   falhas_nxt;
    logic            evento_c;

    assign evento_c = tecla_valid & ~tv_d;

    // State and all registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            estado    <= ENTRADA;
            timer     <= '0;
            cnt       <= '0;
            tv_d      <= 1'b1;
            digitos   <= '0;
            dig_vis   <= '0;
            aberto    <= 1'b0;
            erro      <= 1'b0;
            bloqueado <= 1'b0;
            buzzer    <= 1'b0;
            falhas    <= '0;
        end else begin
            estado    <= estado_nxt;
            timer     <= timer_nxt;
            cnt       <= cnt_nxt;
            tv_d      <= tecla_valid;
            digitos   <= digitos_nxt;
            dig_vis   <= dig_vis_nxt;
            aberto    <= aberto_nxt;
            erro      <= erro_nxt;
            bloqueado <= bloqueado_nxt;
            buzzer    <= buzzer_nxt;
            falhas    <= falhas_nxt;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        estado_nxt    = estado;
        timer_nxt     = timer;
        cnt_nxt       = cnt;
        digitos_nxt   = digitos;
        dig_vis_nxt   = dig_vis;
        aberto_nxt    = aberto;
        erro_nxt      = erro;
        bloqueado_nxt = bloqueado;
        buzzer_nxt    = buzzer;
        falhas_nxt    = falhas;

        case (estado)
            ENTRADA: begin
                if (evento_c) begin
                    if (tecla_value <= 4'd9) begin
                        if (cnt != 3'd4) begin
                            digitos_nxt = {digitos[11:0], tecla_value};
                            dig_vis_nxt = {dig_vis[2:0], 1'b1};
                            cnt_nxt     = cnt + 3'd1;
                        end
                    end else if (tecla_value == TECLA_LIMPA) begin
                        digitos_nxt = '0;
                        dig_vis_nxt = '0;
                        cnt_nxt     = '0;
                    end else if (tecla_value == TECLA_CONFIRMA && cnt == 3'd4) begin
                        estado_nxt = VERIFICA;
                    end
                end
            end

            VERIFICA: begin
                if (digitos == SENHA) begin
                    estado_nxt = ABERTO;
                    timer_nxt  = TW'(T_ABERTO - 1);
                    aberto_nxt = 1'b1;
                    buzzer_nxt = 1'b1;
                    falhas_nxt = '0;
                end else if (32'(falhas) + 32'd1 == MAX_TENT) begin
                    estado_nxt    = BLOQUEIO;
                    timer_nxt     = TW'(T_BLOQ - 1);
                    bloqueado_nxt = 1'b1;
                    falhas_nxt    = FW'(MAX_TENT);
                end else begin
                    estado_nxt = ERRO;
                    timer_nxt  = TW'(T_ERRO - 1);
                    erro_nxt   = 1'b1;
                    buzzer_nxt = 1'b1;
                    falhas_nxt = falhas + FW'(1);
                end
            end

            ABERTO, ERRO, BLOQUEIO: begin
                if (timer == '0) begin
                    estado_nxt    = ENTRADA;
                    digitos_nxt   = '0;
                    dig_vis_nxt   = '0;
                    cnt_nxt       = '0;
                    aberto_nxt    = 1'b0;
                    erro_nxt      = 1'b0;
                    bloqueado_nxt = 1'b0;
                    buzzer_nxt    = 1'b0;
                    if (estado == BLOQUEIO) begin
                        falhas_nxt = '0;
                    end
                end else begin
                    timer_nxt = timer - TW'(1);
                    // Unlock beep covers only the first T_BIP cycles of the state
                    if (estado == ABERTO) begin
                        buzzer_nxt = (32'(timer) - 32'd1 >= T_ABERTO - T_BIP);
                    end
                end
            end

            default: begin
                estado_nxt = ENTRADA;
            end
        endcase
    end

endmodule

// File: tb/tb_controle_senha_teclado.sv
// Bench for controle_senha_teclado: directed plan plus random key traffic, checked
// every cycle against a digit-list / elapsed-time model of the lock.
module tb_controle_senha_teclado;

    localparam logic [15:0] SENHA    = 16'h1234;
    localparam int          T_ABERTO = 8;
    localparam int          T_BIP    = 3;
    localparam int          T_ERRO   = 5;
    localparam int          T_BLOQ   = 12;
    localparam int          MAX_TENT = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        tv  = 1'b0;
    logic [3:0]  val = 4'h0;
    logic [15:0] digitos;
    logic [3:0]  dig_vis;
    logic        aberto, erro, bloqueado, buzzer;
    logic [1:0]  falhas;

    int checks = 0;
    int errors = 0;

    controle_senha_teclado #(
        .SENHA(SENHA), .T_ABERTO(T_ABERTO), .T_BIP(T_BIP),
        .T_ERRO(T_ERRO), .T_BLOQ(T_BLOQ), .MAX_TENT(MAX_TENT)
    ) dut (
        .clk(clk), .rst(rst), .tecla_valid(tv), .tecla_value(val),
        .digitos(digitos), .dig_vis(dig_vis), .aberto(aberto), .erro(erro),
        .bloqueado(bloqueado), .buzzer(buzzer), .falhas(falhas)
    );

    always #5 clk = ~clk;

    // Model: typed digits as a list, a mode, and cycles elapsed in that mode
    typedef enum int {M_IDLE, M_CHECK, M_OPEN, M_WRONG, M_LOCK} mode_t;
    mode_t m_mode;
    int    m_q[$];
    int    m_elapsed;
    int    m_fails;
    bit    m_prev;

    function automatic int m_digitos();
        int v = 0;
        foreach (m_q[i]) v = (v << 4) | m_q[i];
        return v;
    endfunction

    function automatic int m_dur(input mode_t m);
        if (m == M_OPEN)  return T_ABERTO;
        if (m == M_WRONG) return T_ERRO;
        return T_BLOQ;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_mode = M_IDLE; m_q.delete(); m_elapsed = 0; m_fails = 0; m_prev = 1'b1;
        end else begin
            bit ev;
            ev = tv && !m_prev;
            m_prev = tv;
            case (m_mode)
                M_IDLE: if (ev) begin
                    if (val <= 9) begin
                        if (m_q.size() < 4) m_q.push_back(int'(val));
                    end else if (val == 4'hE) m_q.delete();
                    else if (val == 4'hF && m_q.size() == 4) m_mode = M_CHECK;
                end
                M_CHECK: begin
                    m_elapsed = 0;
                    if (m_digitos() == int'(SENHA)) begin
                        m_mode = M_OPEN; m_fails = 0;
                    end else if (m_fails + 1 == MAX_TENT) begin
                        m_mode = M_LOCK; m_fails = MAX_TENT;
                    end else begin
                        m_mode = M_WRONG; m_fails++;
                    end
                end
                default: begin
                    m_elapsed++;
                    if (m_elapsed == m_dur(m_mode)) begin
                        if (m_mode == M_LOCK) m_fails = 0;
                        m_mode = M_IDLE; m_q.delete();
                    end
                end
            endcase
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Per-cycle comparison against the model, away from the rising edge
    always @(negedge clk) begin
        if (rst) begin
            chk("digitos",   32'(digitos),   32'(m_digitos()));
            chk("dig_vis",   32'(dig_vis),   32'((1 << m_q.size()) - 1));
            chk("aberto",    32'(aberto),    32'(m_mode == M_OPEN));
            chk("erro",      32'(erro),      32'(m_mode == M_WRONG));
            chk("bloqueado", 32'(bloqueado), 32'(m_mode == M_LOCK));
            chk("buzzer",    32'(buzzer),
                32'((m_mode == M_OPEN && m_elapsed < T_BIP) || m_mode == M_WRONG));
            chk("falhas",    32'(falhas),    32'(m_fails));
        end
    end

    task automatic press(input logic [3:0] v, input int hold, input int gap);
        @(negedge clk);
        tv = 1'b1; val = v;
        repeat (hold) @(negedge clk);
        tv = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic enter(input logic [15:0] code);
        for (int i = 3; i >= 0; i--) press(code[4*i +: 4], 3, 2);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_reset();
        #2 rst = 1'b0;
        #1;
        chk("rst_digitos", 32'(digitos), 32'h0);
        chk("rst_ind", 32'({aberto, erro, bloqueado, buzzer, dig_vis}), 32'h0);
        @(negedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        logic [15:0] code;
        #12 rst = 1'b1;
        @(negedge clk);
        chk("reset_digitos", 32'(digitos), 32'h0);
        chk("reset_falhas", 32'(falhas), 32'h0);

        // 1: correct password, timing of aberto/buzzer
        press(4'h1, 3, 2); chk("p1_d1", 32'({digitos, dig_vis}), 32'h0001_1);
        press(4'h2, 3, 2); chk("p1_d2", 32'({digitos, dig_vis}), 32'h0012_3);
        press(4'h3, 3, 2);
        press(4'h4, 3, 2); chk("p1_d4", 32'({digitos, dig_vis}), 32'h1234_f);
        press(4'hF, 1, 0); chk("p1_verify", 32'(aberto), 32'h0);
        idle(1); chk("p1_open", 32'({aberto, buzzer}), 32'h3);
        idle(3); chk("p1_bip_end", 32'({aberto, buzzer}), 32'h2);
        idle(10); chk("p1_done", 32'({aberto, digitos, dig_vis}), 32'h0);

        // 2: wrong then right
        enter(16'h1235); press(4'hF, 1, 0); idle(1);
        chk("p2_erro", 32'({erro, buzzer, falhas}), 32'h0d);
        idle(8); chk("p2_clear", 32'(digitos), 32'h0);
        enter(16'h1234); press(4'hF, 1, 1);
        chk("p2_ok", 32'({aberto, falhas}), 32'h4);
        idle(12);

        // 3: three wrong entries -> lockout, keys ignored during it
        for (int k = 0; k < 3; k++) begin
            enter(16'h4321); press(4'hF, 1, 1);
            if (k < 2) begin
                chk("p3_falhas", 32'(falhas), 32'(k + 1));
                idle(8);
            end
        end
        chk("p3_bloq", 32'({bloqueado, buzzer, falhas}), 32'h0b);
        press(4'h1, 1, 1); press(4'hE, 1, 1); press(4'h2, 1, 1);
        idle(10);
        chk("p3_exit", 32'({bloqueado, falhas, digitos}), 32'h0);

        // 4: overflow, clear, short confirm, letters
        enter(16'h9876); press(4'h5, 3, 2);
        chk("p4_full", 32'({digitos, dig_vis}), 32'h9876_f);
        press(4'hE, 3, 2); chk("p4_star", 32'({digitos, dig_vis}), 32'h0);
        press(4'h1, 3, 2); press(4'hF, 3, 2);
        chk("p4_short", 32'({erro, digitos}), 32'h0001);
        for (int k = 10; k < 14; k++) press(4'(k), 2, 1);
        chk("p4_letters", 32'(digitos), 32'h0001);

        // 5: long hold and key held across reset release
        press(4'hE, 2, 1);
        press(4'h7, 20, 2); chk("p5_hold", 32'(digitos), 32'h0007);
        @(negedge clk); tv = 1'b1; val = 4'h3;
        #2 rst = 1'b0;
        @(negedge clk); #2 rst = 1'b1;
        idle(5); chk("p5_held_rst", 32'(digitos), 32'h0);
        tv = 1'b0; idle(1);
        press(4'h3, 2, 1); chk("p5_repress", 32'(digitos), 32'h0003);

        // 6: reset mid-ABERTO and mid-entry
        press(4'hE, 1, 1);
        enter(16'h1234); press(4'hF, 1, 0); idle(5);
        chk("p6_in_open", 32'(aberto), 32'h1);
        pulse_reset();
        press(4'h1, 2, 1); press(4'h2, 2, 1);
        pulse_reset();
        press(4'h5, 2, 1); chk("p6_new", 32'({digitos, dig_vis}), 32'h0005_1);
        press(4'hE, 1, 1);

        // Random traffic: password attempts, arbitrary keys, occasional reset
        for (int n = 0; n < 300; n++) begin
            int r;
            r = int'($urandom_range(0, 99));
            if (r < 15) begin
                enter((r < 7) ? SENHA : 16'($urandom));
                for (int i = 0; i < 4; i++) if (code[0]) code = code; // keep code used
                press(4'hF, int'($urandom_range(1, 3)), int'($urandom_range(0, 2)));
            end else if (r < 17) begin
                pulse_reset();
            end else if (r < 25) begin
                idle(int'($urandom_range(1, 15)));
            end else begin
                press(4'($urandom), int'($urandom_range(1, 4)), int'($urandom_range(0, 3)));
            end
        end
        idle(20);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
